// File: rtl/dram_request_queue_if.sv
// Client-side request/response bundle of the DRAM request queue.
// The client drives requests (master); the queue answers with completions (slave).
interface dram_request_queue_if #(
    parameter int unsigned ADDR_W = 27,
    parameter int unsigned DATA_W = 128
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic              rsp_we;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_error;

    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_error
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_we, rsp_rdata, rsp_error
    );
endinterface

// File: rtl/dram_request_queue.sv
// Front end of the DDR3 controller: buffers client requests in an in-order FIFO, issues them one
// at a time over the level strobe / busy handshake and returns read data, acks or timeouts.
module dram_request_queue #(
    parameter int unsigned ADDR_W  = 27,
    parameter int unsigned DATA_W  = 128,
    parameter int unsigned DEPTH   = 4,
    parameter int unsigned TIMEOUT = 4096
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    dram_request_queue_if.slave    client,
    output logic                   ctrl_read,
    output logic                   ctrl_write,
    output logic [ADDR_W-1:0]      ctrl_address,
    output logic [DATA_W-1:0]      ctrl_write_data,
    input  logic [DATA_W-1:0]      ctrl_read_data,
    input  logic                   ctrl_busy,
    output logic [$clog2(DEPTH):0] q_level
);
    localparam int unsigned PtrW = $clog2(DEPTH);
    localparam int unsigned LvlW = PtrW + 1;
    localparam int unsigned CntW = $clog2(TIMEOUT);

    typedef enum logic [1:0] {StIdle, StIssue, StWait, StCapture} state_e;

    // FIFO storage and pointers
    logic              fifo_we_q    [DEPTH];
    logic [ADDR_W-1:0] fifo_addr_q  [DEPTH];
    logic [DATA_W-1:0] fifo_wdata_q [DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [LvlW-1:0]   level_q;
    logic              fifo_empty, fifo_full, push, pop;

    // Issue path
    state_e            state_q, state_d;
    logic              iss_we_q, iss_we_d;
    logic [ADDR_W-1:0] iss_addr_q, iss_addr_d;
    logic [DATA_W-1:0] iss_wdata_q, iss_wdata_d;
    logic [CntW-1:0]   tmo_cnt_q, tmo_cnt_d;
    logic              timeout_hit;
    logic              ctrl_read_q, ctrl_read_d;
    logic              ctrl_write_q, ctrl_write_d;

    // Completion path
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_error_q, rsp_error_d;

    assign fifo_empty = (level_q == '0);
    assign fifo_full  = (level_q == LvlW'(DEPTH));
    assign pop        = (state_q == StIdle) && !fifo_empty && !ctrl_busy;
    // A pop in the same cycle frees the head slot, so a full FIFO can still take a request.
    assign client.req_ready = !fifo_full || pop;
    assign push             = client.req_valid && client.req_ready;

    always_ff @(posedge clk_i) begin
        if (push) begin
            fifo_we_q[wr_ptr_q]    <= client.req_we;
            fifo_addr_q[wr_ptr_q]  <= client.req_addr;
            fifo_wdata_q[wr_ptr_q] <= client.req_wdata;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PtrW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            unique case ({push, pop})
                2'b10:   level_q <= level_q + LvlW'(1);
                2'b01:   level_q <= level_q - LvlW'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign timeout_hit = (tmo_cnt_q == CntW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        iss_we_d     = iss_we_q;
        iss_addr_d   = iss_addr_q;
        iss_wdata_d  = iss_wdata_q;
        tmo_cnt_d    = tmo_cnt_q;
        ctrl_read_d  = ctrl_read_q;
        ctrl_write_d = ctrl_write_q;
        rsp_valid_d  = 1'b0;
        rsp_we_d     = 1'b0;
        rsp_rdata_d  = '0;
        rsp_error_d  = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (pop) begin
                    iss_we_d     = fifo_we_q[rd_ptr_q];
                    iss_addr_d   = fifo_addr_q[rd_ptr_q];
                    iss_wdata_d  = fifo_wdata_q[rd_ptr_q];
                    tmo_cnt_d    = '0;
                    ctrl_write_d = fifo_we_q[rd_ptr_q];
                    ctrl_read_d  = !fifo_we_q[rd_ptr_q];
                    state_d      = StIssue;
                end
            end
            StIssue, StWait: begin
                tmo_cnt_d = tmo_cnt_q + CntW'(1);
                if (timeout_hit) begin
                    ctrl_read_d  = 1'b0;
                    ctrl_write_d = 1'b0;
                    rsp_valid_d  = 1'b1;
                    rsp_we_d     = iss_we_q;
                    rsp_error_d  = 1'b1;
                    state_d      = StIdle;
                end else if (state_q == StIssue) begin
                    // Strobe stays up until the controller is seen busy.
                    if (ctrl_busy) begin
                        ctrl_read_d  = 1'b0;
                        ctrl_write_d = 1'b0;
                        state_d      = StWait;
                    end
                end else if (!ctrl_busy) begin
                    state_d = StCapture;
                end
            end
            StCapture: begin
                // Controller read data is only valid in its first idle cycle.
                rsp_valid_d = 1'b1;
                rsp_we_d    = iss_we_q;
                rsp_rdata_d = iss_we_q ? '0 : ctrl_read_data;
                state_d     = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= StIdle;
            iss_we_q     <= 1'b0;
            iss_addr_q   <= '0;
            iss_wdata_q  <= '0;
            tmo_cnt_q    <= '0;
            ctrl_read_q  <= 1'b0;
            ctrl_write_q <= 1'b0;
            rsp_valid_q  <= 1'b0;
            rsp_we_q     <= 1'b0;
            rsp_rdata_q  <= '0;
            rsp_error_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            iss_we_q     <= iss_we_d;
            iss_addr_q   <= iss_addr_d;
            iss_wdata_q  <= iss_wdata_d;
            tmo_cnt_q    <= tmo_cnt_d;
            ctrl_read_q  <= ctrl_read_d;
            ctrl_write_q <= ctrl_write_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_we_q     <= rsp_we_d;
            rsp_rdata_q  <= rsp_rdata_d;
            rsp_error_q  <= rsp_error_d;
        end
    end

    assign ctrl_read        = ctrl_read_q;
    assign ctrl_write       = ctrl_write_q;
    assign ctrl_address     = iss_addr_q;
    assign ctrl_write_data  = iss_wdata_q;
    assign q_level          = level_q;
    assign client.rsp_valid = rsp_valid_q;
    assign client.rsp_we    = rsp_we_q;
    assign client.rsp_rdata = rsp_rdata_q;
    assign client.rsp_error = rsp_error_q;
endmodule

// File: tb/tb_dram_request_queue.sv
// Randomised scoreboard bench for dram_request_queue with a behavioural DDR3 controller model.
module tb_dram_request_queue;
    localparam int unsigned ADDR_W  = 27;
    localparam int unsigned DATA_W  = 128;
    localparam int unsigned DEPTH   = 4;
    localparam int unsigned TIMEOUT = 64;

    typedef struct {
        logic              we;
        logic              err;
        logic [DATA_W-1:0] rdata;
    } exp_t;

    typedef struct {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } iss_t;

    logic              clk;
    logic              rst_ni;
    logic              ctrl_read, ctrl_write, ctrl_busy;
    logic [ADDR_W-1:0] ctrl_address;
    logic [DATA_W-1:0] ctrl_write_data, ctrl_read_data;
    logic [2:0]        q_level;

    dram_request_queue_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) cif ();

    dram_request_queue #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .client         (cif.slave),
        .ctrl_read      (ctrl_read),
        .ctrl_write     (ctrl_write),
        .ctrl_address   (ctrl_address),
        .ctrl_write_data(ctrl_write_data),
        .ctrl_read_data (ctrl_read_data),
        .ctrl_busy      (ctrl_busy),
        .q_level        (q_level)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input bit ok, input string name, input logic [DATA_W-1:0] act,
                       input logic [DATA_W-1:0] exp);
        total++;
        if (!ok) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic bit is_dead(input logic [ADDR_W-1:0] a);
        return a[3:0] == 4'hF;
    endfunction

    function automatic logic [DATA_W-1:0] rfun(input logic [ADDR_W-1:0] a);
        if (a == 27'h0012345) return {4{32'hDEAD_BEEF}};
        return {4{a ^ 27'h5A5A5A5, 5'h0}};
    endfunction

    // Controller model: ignores "dead" addresses, otherwise busy two cycles after seeing a
    // strobe, for a random length, and updates read data as busy drops.
    logic              init_busy;
    logic              m_busy;
    int                m_phase, m_dly, m_len;
    int                blen_lo, blen_hi;
    logic [ADDR_W-1:0] m_addr;
    logic [DATA_W-1:0] m_rdata;

    assign ctrl_busy      = init_busy | m_busy;
    assign ctrl_read_data = m_rdata;

    always @(posedge clk or negedge rst_ni) begin
        if (!rst_ni) begin
            m_phase <= 0;
            m_busy  <= 1'b0;
            m_dly   <= 0;
            m_len   <= 0;
            m_addr  <= '0;
            m_rdata <= '0;
        end else begin
            case (m_phase)
                0: if ((ctrl_read || ctrl_write) && !init_busy && !is_dead(ctrl_address)) begin
                    m_addr  <= ctrl_address;
                    m_dly   <= 2;
                    m_phase <= 1;
                end
                1: if (m_dly == 1) begin
                    m_busy  <= 1'b1;
                    m_len   <= $urandom_range(blen_hi, blen_lo);
                    m_rdata <= {$urandom, $urandom, $urandom, $urandom};
                    m_phase <= 2;
                end else begin
                    m_dly <= m_dly - 1;
                end
                2: if (m_len <= 1) begin
                    m_busy  <= 1'b0;
                    m_rdata <= rfun(m_addr);
                    m_phase <= 0;
                end else begin
                    m_len <= m_len - 1;
                end
                default: m_phase <= 0;
            endcase
        end
    end

    // Reference model and monitor: one request outstanding at a time, next one leaves the
    // queue once the previous has completed and the controller is not busy.
    exp_t exp_q[$];
    iss_t iss_q[$];
    int   count, run, since_fall, full_pp, tout_seen, gate_stb;
    bit   inflight, prev_stb, prev_bs, prev_mbusy, cur_dead;

    initial begin
        count = 0; run = 0; since_fall = 100; full_pp = 0; tout_seen = 0; gate_stb = 0;
        inflight = 0; prev_stb = 0; prev_bs = 0; prev_mbusy = 0; cur_dead = 0;
    end

    always @(negedge clk) begin
        exp_t e;
        iss_t s;
        bit   can_pop, push, stb;
        if (!rst_ni) begin
            exp_q.delete();
            iss_q.delete();
            count = 0; inflight = 0; prev_stb = 0; prev_bs = 0; prev_mbusy = 0;
            since_fall = 100;
        end else begin
            since_fall = (prev_mbusy && !m_busy) ? 0 : since_fall + 1;
            prev_mbusy = m_busy;
            if (cif.rsp_valid) begin
                if (exp_q.size() == 0) begin
                    chk(1'b0, "rsp_unexpected", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk(cif.rsp_we == e.we, "rsp_we", cif.rsp_we, e.we);
                    chk(cif.rsp_error == e.err, "rsp_error", cif.rsp_error, e.err);
                    chk(cif.rsp_rdata == e.rdata, "rsp_rdata", cif.rsp_rdata, e.rdata);
                    if (e.err) tout_seen++;
                    else chk(since_fall == 2, "rsp_latency", since_fall, 2);
                end
                inflight = 0;
            end
            chk(q_level == count, "q_level", q_level, count);
            can_pop = !inflight && count > 0 && !ctrl_busy;
            chk(cif.req_ready == (count < DEPTH || can_pop), "req_ready", cif.req_ready,
                (count < DEPTH || can_pop));
            push = cif.req_valid && cif.req_ready;
            if (push && can_pop && count == DEPTH) full_pp++;
            if (push) begin
                e.we    = cif.req_we;
                e.err   = is_dead(cif.req_addr);
                e.rdata = (e.err || cif.req_we) ? '0 : rfun(cif.req_addr);
                exp_q.push_back(e);
                s.we = cif.req_we; s.addr = cif.req_addr; s.wdata = cif.req_wdata;
                iss_q.push_back(s);
            end
            if (can_pop) inflight = 1;
            count = count + int'(push) - int'(can_pop);

            stb = ctrl_read || ctrl_write;
            if (ctrl_read && ctrl_write) chk(1'b0, "strobe_both", 1, 0);
            if (init_busy && stb) gate_stb++;
            if (stb && !prev_stb) begin
                if (iss_q.size() == 0) begin
                    chk(1'b0, "strobe_unexpected", 1, 0);
                end else begin
                    s = iss_q.pop_front();
                    chk(ctrl_write == s.we && ctrl_read == !s.we, "strobe_type", ctrl_write,
                        s.we);
                    chk(ctrl_address == s.addr, "ctrl_address", ctrl_address, s.addr);
                    if (s.we) chk(ctrl_write_data == s.wdata, "ctrl_wdata", ctrl_write_data,
                                  s.wdata);
                    cur_dead = is_dead(s.addr);
                end
                run = 0;
            end
            if (stb) run++;
            if (prev_bs && stb) chk(1'b0, "strobe_after_busy", 1, 0);
            if (!stb && prev_stb) begin
                if (cur_dead) chk(run == TIMEOUT, "timeout_len", run, TIMEOUT);
                else chk(prev_bs, "strobe_early_drop", 0, 1);
            end
            prev_bs  = stb && ctrl_busy;
            prev_stb = stb;
        end
    end

    task automatic push_req(input logic we, input logic [ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d);
        int n;
        @(posedge clk);
        #1;
        cif.req_valid = 1'b1; cif.req_we = we; cif.req_addr = a; cif.req_wdata = d;
        n = 0;
        @(negedge clk);
        while (!cif.req_ready && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 3000, "push_wait", n, 3000);
        @(posedge clk);
        #1;
        cif.req_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || count != 0) && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk(n < 5000, "drain_wait", n, 5000);
    endtask

    initial begin
        logic              w;
        logic [ADDR_W-1:0] a;
        logic [DATA_W-1:0] d;
        int                n;
        cif.req_valid = 1'b0; cif.req_we = 1'b0; cif.req_addr = '0; cif.req_wdata = '0;
        init_busy = 1'b0; blen_lo = 2; blen_hi = 20;
        rst_ni = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk(cif.req_ready == 1'b1, "rst_req_ready", cif.req_ready, 1);
        chk(cif.rsp_valid == 1'b0, "rst_rsp_valid", cif.rsp_valid, 0);
        chk(ctrl_read == 1'b0 && ctrl_write == 1'b0, "rst_strobes", {ctrl_read, ctrl_write}, 0);
        chk(q_level == 3'd0, "rst_q_level", q_level, 0);
        chk(ctrl_address == '0, "rst_ctrl_address", ctrl_address, 0);
        chk(cif.rsp_rdata == '0, "rst_rsp_rdata", cif.rsp_rdata, 0);
        @(negedge clk);
        rst_ni = 1'b1;

        // Controller initialising: requests queue up but nothing issues.
        init_busy = 1'b1; blen_lo = 30; blen_hi = 30;
        push_req(1'b1, 27'h0012345, {16{8'hA5}});
        push_req(1'b0, 27'h0012345, '0);
        repeat (1000) @(posedge clk);
        @(negedge clk);
        chk(q_level == 3'd2, "gate_q_level", q_level, 2);
        chk(cif.req_ready == 1'b1, "gate_req_ready", cif.req_ready, 1);
        chk(gate_stb == 0, "gate_strobe", gate_stb, 0);
        @(posedge clk);
        #1;
        init_busy = 1'b0;
        n = 0;
        while (n < 4) begin
            @(negedge clk);
            n++;
            if (ctrl_read || ctrl_write) break;
        end
        chk((ctrl_read || ctrl_write) && n <= 2, "gate_release", n, 2);
        wait_drain();

        // Random traffic with occasional dead addresses that must time out.
        blen_lo = 2; blen_hi = 20;
        for (int i = 0; i < 150; i++) begin
            w = 1'(($urandom & 1));
            a = ADDR_W'($urandom);
            if ($urandom_range(9, 0) == 0) a[3:0] = 4'hF;
            else if (a[3:0] == 4'hF) a[3:0] = 4'h0;
            d = {$urandom, $urandom, $urandom, $urandom};
            push_req(w, a, d);
            repeat ($urandom_range(3, 0)) @(posedge clk);
        end
        wait_drain();

        // Fill while the controller is busy, then push into a full FIFO as it pops.
        @(posedge clk);
        #1;
        init_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_req(1'(i & 1), ADDR_W'(32'h100 + 32'h10 * i), {4{$urandom}});
        end
        @(negedge clk);
        chk(cif.req_ready == 1'b0, "full_req_ready", cif.req_ready, 0);
        chk(q_level == 3'd4, "full_q_level", q_level, 4);
        @(posedge clk);
        #1;
        cif.req_valid = 1'b1; cif.req_we = 1'b0; cif.req_addr = 27'h0000777; cif.req_wdata = '0;
        init_busy = 1'b0;
        n = 0;
        @(negedge clk);
        while (!cif.req_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(n < 100, "full_push_wait", n, 100);
        @(posedge clk);
        #1;
        cif.req_valid = 1'b0;
        wait_drain();
        chk(full_pp > 0, "full_push_pop", full_pp, 1);

        // Explicit timeout followed by a normal request.
        push_req(1'b1, 27'h00ABC0F, {4{32'h1234_5678}});
        push_req(1'b0, 27'h00ABC01, '0);
        wait_drain();
        chk(tout_seen > 0, "timeout_seen", tout_seen, 1);

        // Asynchronous reset in the middle of a long access with requests still queued.
        blen_lo = 40; blen_hi = 40;
        push_req(1'b0, 27'h0ABCDE0, '0);
        n = 0;
        while (!m_busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk(m_busy == 1'b1, "rst_reach_wait", m_busy, 1);
        push_req(1'b1, 27'h0000220, {4{32'hCAFE_F00D}});
        push_req(1'b0, 27'h0000330, '0);
        @(posedge clk);
        #3;
        rst_ni = 1'b0;
        #1;
        chk(ctrl_read == 1'b0 && ctrl_write == 1'b0, "arst_strobes", {ctrl_read, ctrl_write}, 0);
        chk(cif.rsp_valid == 1'b0, "arst_rsp_valid", cif.rsp_valid, 0);
        chk(q_level == 3'd0, "arst_q_level", q_level, 0);
        chk(cif.req_ready == 1'b1, "arst_req_ready", cif.req_ready, 1);
        repeat (3) @(negedge clk);
        #2;
        rst_ni = 1'b1;
        n = 0;
        repeat (30) begin
            @(negedge clk);
            if (cif.rsp_valid || ctrl_read || ctrl_write) n++;
        end
        chk(n == 0, "arst_quiet", n, 0);
        chk(exp_q.size() == 0, "final_queue_empty", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
